// File: rtl/njp_micro_div.sv
// njp_micro_div: sequential restoring divider producing one quotient bit per clock.
// Optional macro NJP_DIV_SIGNED_EN selects two's-complement operands (adds a sign-fix state).
module njp_micro_div #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [1:0]       dbg_state
);
  localparam int CW = $clog2(DVD_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  // Handshake: start is a level request accepted only on an IDLE edge (no queueing);
  // busy is high from that edge until done, and done is a one-cycle pulse with results valid.
  state_t           state_q;
  logic [DVD_W-1:0] dvd_q, quotient_q;
  logic [DVS_W-1:0] dvs_q, remainder_q;
  logic [DVS_W:0]   p_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, dbz_q;

  logic [DVS_W:0]   p_shift, p_diff, p_d;
  logic             p_ge, dvs_zero;
  logic [DVD_W-1:0] dvd_in;
  logic [DVS_W-1:0] dvs_in;
`ifdef NJP_DIV_SIGNED_EN
  logic             sdvd_q, sdvs_q;
`endif

  always_comb begin
    p_shift  = (p_q << 1) | {{DVS_W{1'b0}}, dvd_q[DVD_W-1]};
    p_ge     = p_shift >= {1'b0, dvs_q};
    p_diff   = p_shift - {1'b0, dvs_q};
    p_d      = p_ge ? p_diff : p_shift;
    dvs_zero = (dvs_q == '0);
`ifdef NJP_DIV_SIGNED_EN
    // A zero divisor keeps the raw dividend so its low bits can be returned as remainder.
    dvd_in   = (dividend[DVD_W-1] && (divisor != '0)) ? -dividend : dividend;
    dvs_in   = divisor[DVS_W-1] ? -divisor : divisor;
`else
    dvd_in   = dividend;
    dvs_in   = divisor;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
`ifdef NJP_DIV_SIGNED_EN
      sdvd_q      <= 1'b0;
      sdvs_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dvd_q   <= dvd_in;
            dvs_q   <= dvs_in;
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ITER;
`ifdef NJP_DIV_SIGNED_EN
            sdvd_q  <= dividend[DVD_W-1];
            sdvs_q  <= divisor[DVS_W-1];
`endif
          end
        end
        S_ITER: begin
          // A zero divisor skips the iterations but still spends this edge.
          if (dvs_zero) begin
            state_q <= S_DONE;
          end else begin
            p_q   <= p_d;
            dvd_q <= {dvd_q[DVD_W-2:0], p_ge};
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(DVD_W - 1)) begin
`ifdef NJP_DIV_SIGNED_EN
              state_q <= S_FIX;
`else
              state_q <= S_DONE;
`endif
            end
          end
        end
`ifdef NJP_DIV_SIGNED_EN
        S_FIX: begin
          if (sdvd_q ^ sdvs_q) dvd_q <= -dvd_q;
          if (sdvd_q) p_q <= -p_q;
          state_q <= S_DONE;
        end
`endif
        S_DONE: begin
          if (dvs_zero) begin
            quotient_q  <= '1;
            remainder_q <= dvd_q[DVS_W-1:0];
            dbz_q       <= 1'b1;
          end else begin
            quotient_q  <= dvd_q;
            remainder_q <= p_q[DVS_W-1:0];
            dbz_q       <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbz       = dbz_q;
  assign dbg_state = state_q;
endmodule
